// File: rtl/key_debounce_pkg.sv
// Shared defaults and helpers for the push-button conditioning block.
package key_debounce_pkg;

  localparam int unsigned CLK_HZ               = 50_000_000;
  localparam int unsigned DEBOUNCE_CYCLES      = CLK_HZ / 100;  // 10 ms
  localparam int unsigned REPEAT_DELAY_CYCLES  = CLK_HZ / 2;    // 500 ms
  localparam int unsigned REPEAT_PERIOD_CYCLES = CLK_HZ / 10;   // 100 ms

  // Width of a counter that runs 0 .. n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One button: 2-flop synchroniser, debounce filter and strobes.
// Auto-repeat press strobes are built only when KEY_REPEAT_EN is defined.
module key_debounce_chan
  import key_debounce_pkg::*;
#(
  parameter int unsigned DebounceCycles     = DEBOUNCE_CYCLES,
  parameter int unsigned RepeatDelayCycles  = REPEAT_DELAY_CYCLES,
  parameter int unsigned RepeatPeriodCycles = REPEAT_PERIOD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int unsigned CntW = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  if (DebounceCycles < 2 || RepeatDelayCycles < 1 || RepeatPeriodCycles < 1) begin : g_bad_param
    $error("key_debounce_chan: cycle parameters out of range");
  end

  logic [1:0]      sync_q;
  logic            sync_k;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;
  logic            rel_q, rel_d;
  logic            accept_press;

  // sync_q[1] is the second (metastability-settled) flop.
  assign sync_k = ~sync_q[1];

  always_comb begin
    stable_d     = stable_q;
    cnt_d        = cnt_q;
    accept_press = 1'b0;
    rel_d        = 1'b0;
    if (sync_k == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      stable_d     = sync_k;
      cnt_d        = '0;
      accept_press = sync_k;
      rel_d        = ~sync_k;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned RepMax =
      (RepeatDelayCycles > RepeatPeriodCycles) ? RepeatDelayCycles : RepeatPeriodCycles;
  localparam int unsigned RepW = cnt_width(RepMax);
  localparam logic [RepW-1:0] RepDelayLast  = RepW'(RepeatDelayCycles - 1);
  localparam logic [RepW-1:0] RepPeriodLast = RepW'(RepeatPeriodCycles - 1);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_first_q, rep_first_d;

  // First repeat waits the long delay, later ones the short period.
  always_comb begin
    press_d     = accept_press;
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    if (accept_press || !stable_d) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (rep_cnt_q == (rep_first_q ? RepDelayLast : RepPeriodLast)) begin
      press_d     = 1'b1;
      rep_cnt_d   = '0;
      rep_first_d = 1'b0;
    end else begin
      rep_cnt_d = rep_cnt_q + RepW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign press_d = accept_press;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key_n};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  assign level = stable_q;
  assign press = press_q;
  assign rel   = rel_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces the board push-buttons feeding the buttons PIO; one channel per key.
// Define KEY_REPEAT_EN to add auto-repeat press strobes while a key is held.
module key_debounce #(
  parameter int unsigned NUM_KEYS             = 4,
  parameter int unsigned DEBOUNCE_CYCLES      = key_debounce_pkg::DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY_CYCLES  = key_debounce_pkg::REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_PERIOD_CYCLES = key_debounce_pkg::REPEAT_PERIOD_CYCLES
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] buttons_export,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .DebounceCycles     (DEBOUNCE_CYCLES),
      .RepeatDelayCycles  (REPEAT_DELAY_CYCLES),
      .RepeatPeriodCycles (REPEAT_PERIOD_CYCLES)
    ) u_chan (
      .clk   (clk_clk),
      .rst   (reset_reset),
      .key_n (key_n[i]),
      .level (buttons_export[i]),
      .press (press_pulse[i]),
      .rel   (release_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus random bouncing
// keys, all compared every cycle against a behavioural model.
module tb_key_debounce;

  localparam int unsigned NK = 4;
  localparam int unsigned DB = 8;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_n;
  logic [NK-1:0] buttons_export, press_pulse, release_pulse;

  always #5 clk = ~clk;

  key_debounce #(
    .NUM_KEYS             (NK),
    .DEBOUNCE_CYCLES      (DB),
    .REPEAT_DELAY_CYCLES  (RD),
    .REPEAT_PERIOD_CYCLES (RP)
  ) dut (
    .clk_clk        (clk),
    .reset_reset    (rst),
    .key_n          (key_n),
    .buttons_export (buttons_export),
    .press_pulse    (press_pulse),
    .release_pulse  (release_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: raw samples reach the filter two edges late; a key is accepted once
  // its delayed level has differed from the accepted level for DB edges in a row.
  logic [NK-1:0] m_new, m_old;
  logic [NK-1:0] m_level, m_press, m_rel;
  int            m_run [NK];
  int            m_held[NK];

  task automatic model_step(input logic r, input logic [NK-1:0] kn);
    logic [NK-1:0] seen;
    m_press = '0;
    m_rel   = '0;
    if (r) begin
      m_new   = '1;
      m_old   = '1;
      m_level = '0;
      for (int k = 0; k < NK; k++) begin
        m_run[k]  = 0;
        m_held[k] = 0;
      end
    end else begin
      seen  = ~m_old;
      m_old = m_new;
      m_new = kn;
      for (int k = 0; k < NK; k++) begin
        if (seen[k] != m_level[k]) begin
          m_run[k]++;
          if (m_run[k] == DB) begin
            m_level[k] = seen[k];
            m_run[k]   = 0;
            if (seen[k]) m_press[k] = 1'b1;
            else         m_rel[k]   = 1'b1;
          end
        end else begin
          m_run[k] = 0;
        end
`ifdef KEY_REPEAT_EN
        if (m_press[k]) begin
          m_held[k] = 0;
        end else if (m_level[k]) begin
          m_held[k]++;
          if (m_held[k] == RD || (m_held[k] > RD && (m_held[k] - RD) % RP == 0))
            m_press[k] = 1'b1;
        end
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst, key_n);
    #1;
    check("level", buttons_export, m_level);
    check("press", press_pulse, m_press);
    check("release", release_pulse, m_rel);
  endtask

  initial begin
    rst   = 1'b1;
    key_n = '1;
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset with all keys released.
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle", {buttons_export, press_pulse, release_pulse}, 0);
    end

    // Clean press on key 0.
    key_n[0] = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      check("k0_level", buttons_export[0], (i >= 10) ? 32'd1 : 32'd0);
      check("k0_press", press_pulse[0], (i == 10) ? 32'd1 : 32'd0);
    end

    // Key 1 bounces with short low bursts and must never be accepted.
    for (int rep = 0; rep < 3; rep++) begin
      key_n[1] = 1'b0;
      for (int i = 0; i < 5; i++) begin
        tick();
        check("k1_quiet", {buttons_export[1], press_pulse[1], release_pulse[1]}, 0);
      end
      key_n[1] = 1'b1;
      for (int i = 0; i < 2; i++) begin
        tick();
        check("k1_quiet", {buttons_export[1], press_pulse[1], release_pulse[1]}, 0);
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      check("k1_quiet", {buttons_export[1], press_pulse[1], release_pulse[1]}, 0);
    end

    // Keys 2 and 3 together.
    key_n[3:2] = 2'b00;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i <= 20) check("k23_press", press_pulse[3:2], (i == 10) ? 32'd3 : 32'd0);
    end
    key_n[3:2] = 2'b11;
    for (int i = 1; i <= 14; i++) begin
      tick();
      check("k23_rel", release_pulse[3:2], (i == 10) ? 32'd3 : 32'd0);
    end

    // Reset in the middle of a count while key 0 is held.
    key_n[0] = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    key_n[0] = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    check("rst_outputs", {buttons_export, press_pulse, release_pulse}, 0);
    rst = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      check("k0_redetect_press", press_pulse[0], (j == 10) ? 32'd1 : 32'd0);
      check("k0_redetect_level", buttons_export[0], (j >= 10) ? 32'd1 : 32'd0);
    end

    // Reset while the key is accepted: level drops, no release strobe.
    rst = 1'b1;
    tick();
    check("rst_no_release", release_pulse[0], 0);
    check("rst_level_drop", buttons_export[0], 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick();

`ifdef KEY_REPEAT_EN
    key_n = '1;
    for (int i = 0; i < 20; i++) tick();
    key_n[0] = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      check("rep_press", press_pulse[0],
            (i == 10 || i == 30 || i == 36 || i == 42 || i == 48 || i == 54) ? 32'd1 : 32'd0);
    end
    key_n[0] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      check("rep_after_release", press_pulse[0], 0);
    end
`endif

    // Random bouncing on all keys, alternating noisy and calmer segments.
    for (int c = 0; c < 4000; c++) begin
      int unsigned thr;
      thr = ((c / 500) % 2 == 1) ? 3 : 19;
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(thr, 0) == 0) key_n[k] = ~key_n[k];
      end
      rst = ($urandom_range(999, 0) == 0);
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
